// File: rtl/div2_seq_if.sv
// Operand/result handshake bundle for div2_seq; remainder exists only with DIV2_SEQ_REM_EN.
// master drives operands and out_ready, slave (the divider) drives results and in_ready.
interface div2_seq_if #(
    parameter int W = 2
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] quotient;
`ifdef DIV2_SEQ_REM_EN
    logic [W-1:0]   remainder;
`endif
    logic           div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient,
`ifdef DIV2_SEQ_REM_EN
        input  remainder,
`endif
        input  div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient,
`ifdef DIV2_SEQ_REM_EN
        output remainder,
`endif
        output div_zero
    );
endinterface

// File: rtl/div2_seq.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor; remainder output with DIV2_SEQ_REM_EN.
// Latency: out_valid 2W+1 cycles after accept (next cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; one operation in flight, in_ready only in IDLE.
module div2_seq #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    div2_seq_if.slave    bus
);
    localparam int CW = $clog2(2*W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [2*W-1:0] dvd_q;
    logic [W-1:0]   dsr_q;
    logic [W-1:0]   prem_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] quo_q;
`ifdef DIV2_SEQ_REM_EN
    logic [W-1:0]   rem_q;
`endif
    logic           dz_q;

    logic           accept;
    logic           last_step;
    logic [W:0]     trial;
    logic           borrow;
    logic [W-1:0]   rem_nxt;
    logic [2*W-1:0] dvd_nxt;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quo_q;
`ifdef DIV2_SEQ_REM_EN
    assign bus.remainder = rem_q;
`endif
    assign bus.div_zero  = dz_q;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign last_step = (cnt_q == CW'(2*W - 1));

    // The partial remainder is always below the divisor, so when no borrow
    // occurs the low W bits of the subtraction are the exact difference.
    assign trial   = {prem_q, dvd_q[2*W-1]};
    assign borrow  = (trial < {1'b0, dsr_q});
    assign rem_nxt = borrow ? trial[W-1:0] : (trial[W-1:0] - dsr_q);
    assign dvd_nxt = {dvd_q[2*W-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (bus.divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
`ifdef DIV2_SEQ_REM_EN
            rem_q  <= '0;
`endif
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dvd_q  <= bus.dividend;
                        dsr_q  <= bus.divisor;
                        prem_q <= '0;
                        cnt_q  <= '0;
                        if (bus.divisor == '0) begin
                            quo_q <= '1;
`ifdef DIV2_SEQ_REM_EN
                            rem_q <= bus.dividend[W-1:0];
`endif
                            dz_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dvd_q  <= dvd_nxt;
                    prem_q <= rem_nxt;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_step) begin
                        quo_q <= dvd_nxt;
`ifdef DIV2_SEQ_REM_EN
                        rem_q <= rem_nxt;
`endif
                        dz_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div2_seq.sv
// Directed vector table, reset-abort sequence and exhaustive 16x4 sweep for div2_seq with W=2.
module tb_div2_seq;
    localparam int W = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div2_seq_if #(.W(W)) bus ();

    div2_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [1:0] b;
        int         hold;
        logic [3:0] q;
        logic [1:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] a, input logic [1:0] b,
                          input int hold, input logic [3:0] eq, input logic [1:0] er,
                          input logic edz, input int elat);
        int lat;
        @(negedge clk);
        check({name, "/ready_before"}, 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        check({name, "/ready_after_accept"}, 32'(bus.in_ready), 0);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'(elat));
        check({name, "/quotient"}, 32'(bus.quotient), 32'(eq));
`ifdef DIV2_SEQ_REM_EN
        check({name, "/remainder"}, 32'(bus.remainder), 32'(er));
`endif
        check({name, "/div_zero"}, 32'(bus.div_zero), 32'(edz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "/hold_valid"}, 32'(bus.out_valid), 1);
            check({name, "/hold_ready"}, 32'(bus.in_ready), 0);
            check({name, "/hold_quotient"}, 32'(bus.quotient), 32'(eq));
`ifdef DIV2_SEQ_REM_EN
            check({name, "/hold_remainder"}, 32'(bus.remainder), 32'(er));
`endif
            check({name, "/hold_div_zero"}, 32'(bus.div_zero), 32'(edz));
        end
        // Offer new operands on the release edge; they must not be taken.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check({name, "/valid_after_release"}, 32'(bus.out_valid), 0);
        check({name, "/ready_after_release"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic [3:0] eq;
        logic [1:0] er;
        logic       edz;
        int         elat;
        checks = 0;
        errors = 0;

        vecs[0] = '{a: 4'd9,  b: 2'd2, hold: 0,  q: 4'd4,  r: 2'd1, dz: 1'b0, lat: 5};
        vecs[1] = '{a: 4'd15, b: 2'd1, hold: 0,  q: 4'd15, r: 2'd0, dz: 1'b0, lat: 5};
        vecs[2] = '{a: 4'd15, b: 2'd3, hold: 0,  q: 4'd5,  r: 2'd0, dz: 1'b0, lat: 5};
        vecs[3] = '{a: 4'd6,  b: 2'd0, hold: 0,  q: 4'd15, r: 2'd2, dz: 1'b1, lat: 1};
        vecs[4] = '{a: 4'd14, b: 2'd3, hold: 10, q: 4'd4,  r: 2'd2, dz: 1'b0, lat: 5};
        vecs[5] = '{a: 4'd0,  b: 2'd3, hold: 2,  q: 4'd0,  r: 2'd0, dz: 1'b0, lat: 5};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/in_ready", 32'(bus.in_ready), 0);
        check("reset/out_valid", 32'(bus.out_valid), 0);
        check("reset/quotient", 32'(bus.quotient), 0);
`ifdef DIV2_SEQ_REM_EN
        check("reset/remainder", 32'(bus.remainder), 0);
`endif
        check("reset/div_zero", 32'(bus.div_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset/in_ready_after", 32'(bus.in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hold,
                   vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // Reset two cycles after accept abandons the division.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.dividend  = 4'd9;
        bus.divisor   = 2'd2;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort/in_ready_in_reset", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        check("abort/out_valid", 32'(bus.out_valid), 0);
        check("abort/quotient", 32'(bus.quotient), 0);
        check("abort/div_zero", 32'(bus.div_zero), 0);
        rst = 1'b0;
        #1;
        check("abort/in_ready", 32'(bus.in_ready), 1);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("abort/stays_idle", 32'(bus.out_valid), 0);
        end
        run_op("after_abort", 4'd7, 2'd2, 0, 4'd3, 2'd1, 1'b0, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 0) begin
                    eq   = 4'hF;
                    er   = 2'(a);
                    edz  = 1'b1;
                    elat = 1;
                end else begin
                    eq   = 4'(a / b);
                    er   = 2'(a % b);
                    edz  = 1'b0;
                    elat = 5;
                end
                run_op($sformatf("sweep_%0d_%0d", a, b), 4'(a), 2'(b), (a + b) % 3,
                       eq, er, edz, elat);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
